auth_cmd_tx: RTL

AUTH_CMD_TX -- requirements
Module: auth_cmd_tx

---
 rtl/auth_cmd_tx_if.sv | 11 +
 rtl/auth_cmd_tx.sv | 93 +++++++++
 2 files changed

// File: rtl/auth_cmd_tx_if.sv
// auth_cmd_tx_if: request inputs and UART/status outputs of the auth command transmitter
interface auth_cmd_tx_if;
    logic       go_req;
    logic       stop_req;
    logic       TX;
    logic       busy;
    logic       cmd_done;
    logic [7:0] last_cmd;
    modport master (output go_req, stop_req, input TX, busy, cmd_done, last_cmd);
    modport slave (input go_req, stop_req, output TX, busy, cmd_done, last_cmd);
endinterface

// File: rtl/auth_cmd_tx.sv
// auth_cmd_tx: sends GO/STOP command bytes as 8N1 UART frames with a one-entry request slot
module auth_cmd_tx #(
    parameter int         BAUD_DIV  = 2604,
    parameter logic [7:0] GO_CHAR   = 8'h47,
    parameter logic [7:0] STOP_CHAR = 8'h53
) (
    input logic          clk,
    input logic          rst,
    auth_cmd_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    typedef enum logic [1:0] {SLOT_NONE, SLOT_GO, SLOT_STOP} slot_t;
    localparam logic [15:0] LP_LAST = 16'(BAUD_DIV - 1);
    state_t      r_state, w_state_nxt;
    slot_t       r_slot, w_slot_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [7:0]  r_byte, w_byte_nxt;
    logic [7:0]  r_last;
    logic        r_tx, w_tx_nxt;
    logic        r_busy;
    logic        w_load;
    logic        w_bit_end;
    logic        w_done;
    assign w_bit_end    = r_cnt == LP_LAST;
    assign w_done       = (r_state == STOP) && w_bit_end;
    assign bus.TX       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.cmd_done = w_done;
    assign bus.last_cmd = r_last;
    // next-state, bit timing, request slot and the value TX takes after this edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? 16'd0 : r_cnt + 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 16'd0;
                if (r_slot != SLOT_NONE) begin
                    w_load      = 1'b1;
                    w_byte_nxt  = r_slot == SLOT_STOP ? STOP_CHAR : GO_CHAR;
                    w_shift_nxt = w_byte_nxt;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = w_bit_end ? DATA : START;
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit + 3'd1;
                    w_state_nxt = r_bit == 3'd7 ? STOP : DATA;
                end
            end
            STOP: w_state_nxt = w_bit_end ? IDLE : STOP;
        endcase
        // loading frees the slot first so a request in the same cycle is kept for the next frame
        w_slot_nxt = w_load ? SLOT_NONE : r_slot;
        if (bus.stop_req)
            w_slot_nxt = SLOT_STOP;
        else if (bus.go_req && w_slot_nxt != SLOT_STOP)
            w_slot_nxt = SLOT_GO;
        w_tx_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
    end
    // state, counters, slot and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_slot  <= SLOT_NONE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_byte  <= 8'h00;
            r_last  <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_last  <= w_done ? r_byte : r_last;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != IDLE) || (w_slot_nxt != SLOT_NONE);
        end
    end
endmodule
